// File: rtl/nolinear_pkg.sv
// Shared definitions for the nonlinear engine and its scheduler.
package nolinear_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    localparam logic [1:0] MODE_SOFTMAX = 2'b00;
    localparam logic [1:0] MODE_GELU    = 2'b01;
    localparam logic [1:0] MODE_SILU    = 2'b10;
    localparam logic [1:0] MODE_ROOT    = 2'b11;

    // Vector geometry shared with nolinear_top.
    localparam int DEF_DATA_NUM        = 16;
    localparam int DEF_IN_WIDTH        = 8;
    localparam int DEF_FIX_POINT_WIDTH = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first active request at or after
// ptr (wrapping) wins. N must be a power of two so the index wraps for free.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;
    logic          found;

    // Scan from ptr upward and take the first requester seen.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + IW'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/nolinear_sched.sv
// Round-robin scheduler sharing one nonlinear engine among NUM_REQ sources.
// One job in flight: grant, issue a start pulse, wait for finish or timeout,
// then hold the tagged response until the consumer takes it.
//
// state | meaning
// IDLE  | arbitrating; winner's req_ready high
// ISSUE | eng_en pulse, timeout counter cleared
// WAIT  | engine running; finish or timeout ends it
// RESP  | rsp_valid high, response held until rsp_ready
module nolinear_sched
    import nolinear_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int DATA_NUM        = DEF_DATA_NUM,
    parameter int IN_WIDTH        = DEF_IN_WIDTH,
    parameter int FIX_POINT_WIDTH = DEF_FIX_POINT_WIDTH,
    parameter int TIMEOUT         = 255,
    parameter int IDW             = $clog2(NUM_REQ),
    parameter int VIW             = DATA_NUM * IN_WIDTH,
    parameter int VOW             = DATA_NUM * FIX_POINT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    input  logic [NUM_REQ*VIW-1:0] req_data,
    output logic                   eng_en,
    output logic [1:0]             eng_mode,
    output logic [VIW-1:0]         eng_in,
    input  logic                   eng_finish,
    input  logic [VOW-1:0]         eng_out,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_err,
    output logic [VOW-1:0]         rsp_data,
    output logic                   busy
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    sched_state_e   state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] id_q;
    logic [1:0]     mode_q;
    logic [VIW-1:0] data_q;
    logic           eng_en_q;
    logic           rsp_err_q;
    logic [VOW-1:0] rsp_data_q;
    logic [7:0]     cnt_q;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;

    rr_arbiter #(.N(NUM_REQ), .IW(IDW)) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Grants are only offered in IDLE and are forced low while reset is held.
    assign req_ready = (state_q == ST_IDLE && rst) ? gnt : '0;

    assign eng_en    = eng_en_q;
    assign eng_mode  = mode_q;
    assign eng_in    = data_q;
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);

    // Job sequencer: latches the winning job, times the engine, holds the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            mode_q     <= '0;
            data_q     <= '0;
            eng_en_q   <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            eng_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_valid) begin
                        mode_q   <= req_mode[int'(gnt_idx)*2 +: 2];
                        data_q   <= req_data[int'(gnt_idx)*VIW +: VIW];
                        id_q     <= gnt_idx;
                        rr_ptr_q <= gnt_idx + 1'b1;
                        eng_en_q <= 1'b1;
                        state_q  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Finish takes priority over a timeout in the same cycle.
                    if (eng_finish) begin
                        rsp_data_q <= eng_out;
                        rsp_err_q  <= 1'b0;
                        state_q    <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST_WAIT) begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= ST_RESP;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nolinear_sched.sv
// Directed/randomized bench for nolinear_sched with a behavioural RR model.
module tb_nolinear_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [7:0]   req_mode;
    logic [511:0] req_data;
    logic         eng_en;
    logic [1:0]   eng_mode;
    logic [127:0] eng_in;
    logic         eng_finish;
    logic [255:0] eng_out;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic         rsp_err;
    logic [255:0] rsp_data;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int           ptr_m = 0;
    logic [1:0]   mode_a [4];
    logic [127:0] dvec   [4];

    nolinear_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_data   (req_data),
        .eng_en     (eng_en),
        .eng_mode   (eng_mode),
        .eng_in     (eng_in),
        .eng_finish (eng_finish),
        .eng_out    (eng_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic apply();
        for (int r = 0; r < 4; r++) begin
            req_data[r*128 +: 128] = dvec[r];
            req_mode[r*2 +: 2]     = mode_a[r];
        end
    endtask

    task automatic rand_inputs();
        for (int r = 0; r < 4; r++) begin
            mode_a[r] = 2'($urandom);
            for (int l = 0; l < 4; l++) dvec[r][l*32 +: 32] = $urandom;
        end
        apply();
    endtask

    // First requester at or after the model pointer, wrapping.
    function automatic int exp_winner(input logic [3:0] mask);
        for (int k = 0; k < 4; k++)
            if (mask[(ptr_m + k) % 4]) return (ptr_m + k) % 4;
        return -1;
    endfunction

    // One complete job. lat = WAIT cycle on which finish is raised (>255: never).
    // hold = cycles of rsp_ready low in RESP. gidx returns the DUT's grant index.
    task automatic run_job(input logic [3:0] mask, input int lat, input int hold,
                           input logic [255:0] out, output int gidx);
        int           win;
        int           stop;
        logic [3:0]   eg;
        logic         experr;
        logic [255:0] expd;
        @(negedge clk);
        req_valid  = mask;
        rsp_ready  = 1'b0;
        eng_finish = 1'b0;
        #1;
        win  = exp_winner(mask);
        eg   = 4'b0001 << win;
        gidx = -1;
        for (int i = 0; i < 4; i++) if (req_ready[i]) gidx = i;
        chk("grant", {252'd0, req_ready}, {252'd0, eg});
        chk("idle_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        chk("issue_en", {255'd0, eng_en}, 256'd1);
        chk("issue_mode", {254'd0, eng_mode}, {254'd0, mode_a[win]});
        chk("issue_in", {128'd0, eng_in}, {128'd0, dvec[win]});
        chk("issue_ready", {252'd0, req_ready}, 256'd0);
        ptr_m = (win + 1) % 4;
        stop  = (lat <= 255) ? lat : 255;
        for (int w = 1; w <= stop; w++) begin
            @(negedge clk);
            chk("wait_en", {255'd0, eng_en}, 256'd0);
            chk("wait_valid", {255'd0, rsp_valid}, 256'd0);
            chk("wait_in", {128'd0, eng_in}, {128'd0, dvec[win]});
            chk("wait_ready", {252'd0, req_ready}, 256'd0);
            eng_finish = (w == lat);
            eng_out    = (w == lat) ? out : rand_vec();
        end
        @(negedge clk);
        eng_finish = 1'b0;
        experr = (lat > 255);
        expd   = experr ? 256'd0 : out;
        chk("rsp_valid", {255'd0, rsp_valid}, 256'd1);
        chk("rsp_err", {255'd0, rsp_err}, {255'd0, experr});
        chk("rsp_data", rsp_data, expd);
        chk("rsp_id", {254'd0, rsp_id}, 256'(win));
        chk("rsp_busy", {255'd0, busy}, 256'd1);
        for (int h = 0; h < hold; h++) begin
            eng_finish = 1'b1;
            eng_out    = rand_vec();
            @(negedge clk);
            chk("hold_valid", {255'd0, rsp_valid}, 256'd1);
            chk("hold_err", {255'd0, rsp_err}, {255'd0, experr});
            chk("hold_data", rsp_data, expd);
            chk("hold_id", {254'd0, rsp_id}, 256'(win));
            chk("hold_ready", {252'd0, req_ready}, 256'd0);
        end
        eng_finish = 1'b0;
        rsp_ready  = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'd0;
        #1;
        chk("done_valid", {255'd0, rsp_valid}, 256'd0);
        chk("done_busy", {255'd0, busy}, 256'd0);
        chk("done_in_held", {128'd0, eng_in}, {128'd0, dvec[win]});
    endtask

    initial begin
        int         g;
        int         w1;
        logic [3:0] m;

        rst        = 1'b0;
        req_valid  = 4'hF;
        rsp_ready  = 1'b0;
        eng_finish = 1'b0;
        eng_out    = '0;
        rand_inputs();
        #12;
        chk("rst_ready", {252'd0, req_ready}, 256'd0);
        chk("rst_en", {255'd0, eng_en}, 256'd0);
        chk("rst_in", {128'd0, eng_in}, 256'd0);
        chk("rst_mode", {254'd0, eng_mode}, 256'd0);
        chk("rst_valid", {255'd0, rsp_valid}, 256'd0);
        chk("rst_data", rsp_data, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        @(negedge clk);
        req_valid = 4'd0;
        rst       = 1'b1;

        // Idle with no requests
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", {252'd0, req_ready}, 256'd0);
            chk("idle_busy0", {255'd0, busy}, 256'd0);
        end

        // Single job: requester 2, gelu, 0x10 lanes, finish after 20 cycles
        rand_inputs();
        mode_a[2] = 2'b01;
        dvec[2]   = {16{8'h10}};
        apply();
        run_job(4'b0100, 20, 0, {16{16'h1234}}, g);
        chk("single_id", 256'(g), 256'd2);

        // Bring pointer back to 0, then fairness over 8 jobs
        rand_inputs();
        run_job(4'b1000, 3, 0, rand_vec(), g);
        for (int j = 0; j < 8; j++) begin
            rand_inputs();
            run_job(4'hF, int'($urandom_range(1, 12)), 0, rand_vec(), g);
            chk("fair_order", 256'(g), 256'(j % 4));
        end

        // Back-pressure
        rand_inputs();
        run_job(4'($urandom_range(1, 15)), 5, 10, rand_vec(), g);

        // Timeout followed by a normal job
        rand_inputs();
        run_job(4'($urandom_range(1, 15)), 1000, 2, rand_vec(), g);
        rand_inputs();
        run_job(4'($urandom_range(1, 15)), 7, 0, rand_vec(), g);

        // Finish on the last possible WAIT cycle
        rand_inputs();
        run_job(4'($urandom_range(1, 15)), 255, 1, rand_vec(), g);

        // Randomized jobs
        for (int j = 0; j < 6; j++) begin
            rand_inputs();
            m = 4'($urandom_range(1, 15));
            run_job(m, int'($urandom_range(1, 30)), int'($urandom_range(0, 3)), rand_vec(), g);
        end

        // Reset during WAIT: requester 1 granted (pointer becomes 2), then abort
        rand_inputs();
        @(negedge clk);
        req_valid = 4'b0010;
        w1 = exp_winner(4'b0010);
        @(negedge clk);
        chk("pre_rst_en", {255'd0, eng_en}, 256'd1);
        repeat (5) @(negedge clk);
        chk("pre_rst_in", {128'd0, eng_in}, {128'd0, dvec[w1]});
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", {252'd0, req_ready}, 256'd0);
        chk("mid_rst_en", {255'd0, eng_en}, 256'd0);
        chk("mid_rst_in", {128'd0, eng_in}, 256'd0);
        chk("mid_rst_mode", {254'd0, eng_mode}, 256'd0);
        chk("mid_rst_valid", {255'd0, rsp_valid}, 256'd0);
        chk("mid_rst_err", {255'd0, rsp_err}, 256'd0);
        chk("mid_rst_id", {254'd0, rsp_id}, 256'd0);
        chk("mid_rst_data", rsp_data, 256'd0);
        chk("mid_rst_busy", {255'd0, busy}, 256'd0);
        ptr_m = 0;
        @(negedge clk);
        req_valid = 4'd0;
        rst       = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", {255'd0, rsp_valid}, 256'd0);
            chk("post_rst_busy", {255'd0, busy}, 256'd0);
        end
        rand_inputs();
        run_job(4'hF, 4, 0, rand_vec(), g);
        chk("post_rst_ptr", 256'(g), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nolinear_sched.md
# nolinear_sched

Round-robin scheduler that shares one `nolinear_top` engine (softmax/gelu/silu/root) among `NUM_REQ` requesters. It accepts one vector job at a time over per-requester valid/ready channels. It latches the job's operands, launches the engine, waits for `finish` (with a timeout), and returns the captured result tagged with the requester ID. It sits between the accelerator's job sources and the single nonlinear engine.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (power of two, ≥2)
- `DATA_NUM`, 16: elements per vector
- `IN_WIDTH`, 8: input element width
- `FIX_POINT_WIDTH`, 16: output element width
- `TIMEOUT`, 255: max WAIT cycles before abort (8-bit counter)

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, asynchronous, active-low
- `req_valid` in NUM_REQ: job request per requester
- `req_ready` out NUM_REQ: one-hot grant/accept, only in IDLE
- `req_mode` in 2*NUM_REQ: per-requester mode (00 softmax, 01 gelu, 10 silu, 11 root)
- `req_data` in NUM_REQ*DATA_NUM*IN_WIDTH: per-requester operand vector
- `eng_en` out 1: engine start pulse
- `eng_mode` out 2: engine mode
- `eng_in` out DATA_NUM*IN_WIDTH: engine operands
- `eng_finish` in 1: engine completion
- `eng_out` in DATA_NUM*FIX_POINT_WIDTH: engine result, valid when `eng_finish`=1
- `rsp_valid` out 1: result available
- `rsp_ready` in 1: consumer accepts result
- `rsp_id` out $clog2(NUM_REQ): requester of this result
- `rsp_err` out 1: job aborted by timeout; `rsp_data` is zero
- `rsp_data` out DATA_NUM*FIX_POINT_WIDTH: result vector
- `busy` out 1: state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Combinational round-robin grant over `req_valid`, starting at `rr_ptr`. Winner's `req_ready`=1.
  - On handshake: latch `req_mode` slice, `req_data` slice and ID; set `rr_ptr` = winner+1 (mod NUM_REQ); go to ISSUE.
  - No valid requests: stay in IDLE; `rr_ptr` unchanged.
- ISSUE: `eng_en`=1 for exactly one cycle; clear timeout counter; go to WAIT.
- WAIT
  - `eng_mode`/`eng_in` driven from the latches, stable from ISSUE until leaving WAIT.
  - `eng_finish`=1: capture `eng_out` into `rsp_data`, `rsp_err`=0, go to RESP.
  - Otherwise increment counter. On the cycle the counter reaches TIMEOUT without finish: `rsp_data`=0, `rsp_err`=1, go to RESP.
  - `eng_finish` on the same cycle as the timeout: finish wins.
- RESP: `rsp_valid`=1; `rsp_id`, `rsp_err` and `rsp_data` are held stable until `rsp_ready`=1, then go to IDLE.
- `eng_finish` seen outside WAIT is ignored.
- `eng_mode`/`eng_in` hold their last latched values outside WAIT; they are zero after reset.
- Reset values: state IDLE, `rr_ptr`=0, all outputs 0.
- Reset asserted mid-job: immediate abort, no response produced, engine inputs zeroed.

## Timing
- Request handshake in cycle T: ISSUE (`eng_en`=1) in T+1, WAIT starts T+2.
- `eng_finish` in cycle F: `rsp_valid`=1 from F+1.
- Response handshake in cycle R: IDLE in R+1. Next grant no earlier than R+1, so at most one job in flight.
- Minimum job-to-job spacing: 4 cycles plus engine latency.
- `req_ready` is a combinational function of state, `req_valid` and `rr_ptr`; it never depends on `req_data`.
- The timeout abort reaches RESP TIMEOUT+1 cycles after ISSUE.

## Structure
- Shared package `nolinear_pkg`:
  - FSM state enum
  - mode constants MODE_SOFTMAX/GELU/SILU/ROOT
  - default DATA_NUM, FIX_POINT_WIDTH and IN_WIDTH constants, common with `nolinear_top`
- Sub-module `rr_arbiter`:
  - inputs: request vector, pointer
  - outputs: one-hot grant, encoded index
  - purely combinational, reusable by other shared resources.
- Top-level FSM, latches and timeout counter live in `nolinear_sched`.

## Test plan
- Single job: requester 2 sends mode=01 with data 0x10 in all lanes; engine model finishes after 20 cycles with 0x1234 per lane. Required: `eng_en` pulses exactly once at T+1; `rsp_valid` at F+1; `rsp_id`=2; `rsp_data` lanes = 0x1234; `rsp_err`=0.
- Fairness: all 4 `req_valid` held high for 8 jobs starting from `rr_ptr`=0. Required grant order: 0,1,2,3,0,1,2,3.
- Back-pressure: `rsp_ready` held low for 10 cycles after `rsp_valid`. Required: `rsp_*` stable throughout; `req_ready` stays 0 for every requester until the handshake.
- Timeout: engine never asserts `eng_finish`. Required: `rsp_valid` with `rsp_err`=1 and `rsp_data`=0, 256 cycles after ISSUE; the next job proceeds normally.
- Finish/timeout collision: `eng_finish` arrives on the cycle the counter reaches 255. Required: `rsp_err`=0 and the captured data is returned.
- Reset mid-WAIT: `rst` driven low during WAIT. Required: all outputs 0 immediately (asynchronous); after release, state IDLE, `rr_ptr`=0, no stray `rsp_valid`.
